// File: rtl/z88_mem_pkg.sv
// rtl/z88_mem_pkg.sv - shared constants, FSM state type and sizing helper for the z88 memory bus
package z88_mem_pkg;

  localparam int DEV_ROM         = 0;
  localparam int DEV_RAM         = 1;
  localparam int CARD_DEV_OFFSET = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int dev_width(input int ndev);
    return (ndev > 1) ? $clog2(ndev) : 1;
  endfunction

endpackage

// File: rtl/z88_mem_bus_if.sv
// rtl/z88_mem_bus_if.sv - requester-side handshake and data bundle for the z88 memory bus
interface z88_mem_bus_if #(
  parameter int AW = 22
) ();

  logic          req;
  logic          req_we;
  logic [AW-1:0] req_a;
  logic [7:0]    req_wd;
  logic          busy;
  logic          ack;
  logic [7:0]    rd_data;
  logic          wr_fault;

  modport master (
    output req, req_we, req_a, req_wd,
    input  busy, ack, rd_data, wr_fault
  );

  modport slave (
    input  req, req_we, req_a, req_wd,
    output busy, ack, rd_data, wr_fault
  );

endinterface

// File: rtl/z88_mem_decode.sv
// rtl/z88_mem_decode.sv - combinational banked-address to device index / device address decode
module z88_mem_decode
  import z88_mem_pkg::*;
#(
  parameter int NSLOT = 4,
  parameter int AW    = 22,
  parameter int DAW   = 19,
  parameter int DW    = dev_width(NSLOT + 1)
) (
  input  logic [AW-1:0]  req_a,
  output logic [DW-1:0]  dev,
  output logic [DAW-1:0] dev_a,
  output logic           slot_ok
);

  logic [1:0] w_slot;

  assign w_slot  = req_a[AW-1:AW-2];
  assign slot_ok = int'(w_slot) < NSLOT;

  // Slot 0 is split in half between ROM and RAM; cards follow after those two devices.
  assign dev = (w_slot == 2'd0) ? (req_a[AW-3] ? DW'(DEV_RAM) : DW'(DEV_ROM))
                                : DW'(w_slot) + DW'(CARD_DEV_OFFSET);

  assign dev_a = req_a[DAW-1:0];

endmodule

// File: rtl/z88_mem_bus.sv
// rtl/z88_mem_bus.sv - z88 memory bus controller: decode, wait-state strobe FSM, protection gating
// Optional sticky write-fault capture is enabled by defining Z88_MEM_FAULT_LATCH_EN.
module z88_mem_bus
  import z88_mem_pkg::*;
#(
  parameter  int NSLOT = 4,
  parameter  int AW    = 22,
  parameter  int DAW   = 19,
  parameter  int WS_W  = 3,
  localparam int NDEV  = NSLOT + 1,
  localparam int DW    = dev_width(NDEV)
) (
  input  logic                   mck,
  input  logic                   rin_n,
  z88_mem_bus_if.slave           bus,
  input  logic [NDEV*WS_W-1:0]   ws_cfg,
  input  logic [NDEV-1:0]        wp_mask,
  input  logic [NDEV-1:0]        present,
  output logic [DAW-1:0]         dev_a,
  output logic [7:0]             dev_wd,
  output logic [NDEV-1:0]        dev_ce_n,
  output logic                   dev_oe_n,
  output logic                   dev_we_n,
  input  logic [NDEV*8-1:0]      dev_rd,
  output logic                   fault_valid,
  output logic [AW-1:0]          fault_a,
  input  logic                   fault_clr
);

  state_e          r_state, w_next;
  logic [DW-1:0]   r_dev, w_dev;
  logic [DAW-1:0]  r_dev_a, w_dev_a;
  logic [7:0]      r_wd, r_rd;
  logic            r_we, r_ok;
  logic [WS_W-1:0] r_cnt;
  logic [NDEV-1:0] w_present_eff, w_prot_eff;
  logic            w_slot_ok, w_ok, w_start, w_last, w_wr_fault;

  z88_mem_decode #(
    .NSLOT (NSLOT),
    .AW    (AW),
    .DAW   (DAW),
    .DW    (DW)
  ) u_decode (
    .req_a   (bus.req_a),
    .dev     (w_dev),
    .dev_a   (w_dev_a),
    .slot_ok (w_slot_ok)
  );

  // Internal ROM/RAM are always fitted, and ROM can never be written.
  assign w_present_eff = present | NDEV'(3);
  assign w_prot_eff    = wp_mask | NDEV'(1);
  assign w_ok    = w_slot_ok && w_present_eff[w_dev] && !(bus.req_we && w_prot_eff[w_dev]);
  assign w_start = (r_state == IDLE) && bus.req;
  assign w_last  = (r_state == STROBE) && (r_cnt == '0);

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req) w_next = SETUP;
      SETUP:   w_next = STROBE;
      STROBE:  if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      r_dev   <= '0;
      r_dev_a <= '0;
      r_wd    <= '0;
      r_we    <= 1'b0;
      r_ok    <= 1'b0;
      r_cnt   <= '0;
      r_rd    <= 8'hFF;
    end else begin
      if (w_start) begin
        r_dev   <= w_dev;
        r_dev_a <= w_dev_a;
        r_wd    <= bus.req_wd;
        r_we    <= bus.req_we;
        r_ok    <= w_ok;
        r_cnt   <= ws_cfg[int'(w_dev)*WS_W +: WS_W];
      end else if ((r_state == STROBE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - WS_W'(1);
      end
      if (w_last && !r_we) r_rd <= r_ok ? dev_rd[int'(r_dev)*8 +: 8] : 8'hFF;
    end
  end

  assign w_wr_fault = (r_state == DONE) && r_we && !r_ok;

  always_comb begin
    dev_ce_n     = '1;
    dev_oe_n     = 1'b1;
    dev_we_n     = 1'b1;
    bus.ack      = 1'b0;
    bus.busy     = (r_state != IDLE);
    bus.wr_fault = 1'b0;
    case (r_state)
      SETUP:  if (r_ok) dev_ce_n[r_dev] = 1'b0;
      STROBE: if (r_ok) begin
        dev_ce_n[r_dev] = 1'b0;
        dev_oe_n        = r_we;
        dev_we_n        = !r_we;
      end
      DONE: begin
        bus.ack      = 1'b1;
        bus.wr_fault = w_wr_fault;
      end
      default: ;
    endcase
  end

  assign dev_a       = r_dev_a;
  assign dev_wd      = r_wd;
  assign bus.rd_data = r_rd;

`ifdef Z88_MEM_FAULT_LATCH_EN
  logic [AW-1:0] r_req_a, r_fault_a;
  logic          r_fault_valid;

  // A fault arriving together with a clear is kept: the clear only acknowledges older faults.
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      r_req_a       <= '0;
      r_fault_a     <= '0;
      r_fault_valid <= 1'b0;
    end else begin
      if (w_start) r_req_a <= bus.req_a;
      if (w_wr_fault && (!r_fault_valid || fault_clr)) begin
        r_fault_a     <= r_req_a;
        r_fault_valid <= 1'b1;
      end else if (fault_clr) begin
        r_fault_valid <= 1'b0;
      end
    end
  end

  assign fault_valid = r_fault_valid;
  assign fault_a     = r_fault_a;
`else
  logic w_unused_fault_clr;
  assign w_unused_fault_clr = fault_clr;
  assign fault_valid        = 1'b0;
  assign fault_a            = '0;
`endif

endmodule

// File: tb/tb_z88_mem_bus.sv
// tb/tb_z88_mem_bus.sv - directed scoreboard bench for the z88 memory bus controller
module tb_z88_mem_bus;

  typedef struct packed {
    logic [7:0] rd;
    logic       chk_rd;
    logic       wf;
    logic [7:0] lat;
    logic [7:0] ce;
    logic [7:0] oe;
    logic [7:0] we;
  } exp_t;

  logic        mck;
  logic        rin_n;
  logic [14:0] ws_cfg;
  logic [4:0]  wp_mask;
  logic [4:0]  present;
  logic [18:0] dev_a;
  logic [7:0]  dev_wd;
  logic [4:0]  dev_ce_n;
  logic        dev_oe_n;
  logic        dev_we_n;
  logic [39:0] dev_rd;
  logic        fault_valid;
  logic [21:0] fault_a;
  logic        fault_clr;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  exp_t sb[$];

  z88_mem_bus_if #(.AW(22)) bus ();

  z88_mem_bus dut (
    .mck         (mck),
    .rin_n       (rin_n),
    .bus         (bus),
    .ws_cfg      (ws_cfg),
    .wp_mask     (wp_mask),
    .present     (present),
    .dev_a       (dev_a),
    .dev_wd      (dev_wd),
    .dev_ce_n    (dev_ce_n),
    .dev_oe_n    (dev_oe_n),
    .dev_we_n    (dev_we_n),
    .dev_rd      (dev_rd),
    .fault_valid (fault_valid),
    .fault_a     (fault_a),
    .fault_clr   (fault_clr)
  );

  initial mck = 1'b0;
  always #5 mck = ~mck;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge mck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [21:0] a);
    exp_t e;
    int   slot;
    int   dev;
    int   ws;
    logic ok;
    slot     = int'(a[21:20]);
    dev      = (slot == 0) ? int'(a[19]) : slot + 1;
    ws       = int'(ws_cfg[dev*3 +: 3]);
    ok       = ((dev < 2) || present[dev]) && !(we && ((dev == 0) || wp_mask[dev]));
    e.lat    = 8'(ws + 3);
    e.ce     = ok ? 8'(ws + 2) : 8'd0;
    e.oe     = (ok && !we) ? 8'(ws + 1) : 8'd0;
    e.we     = (ok && we) ? 8'(ws + 1) : 8'd0;
    e.wf     = we && !ok;
    e.chk_rd = !we;
    e.rd     = ok ? dev_rd[dev*8 +: 8] : 8'hFF;
    return e;
  endfunction

  task automatic access(input string tag, input logic we, input logic [21:0] a,
                        input logic [7:0] wd, input logic hold, input logic clr_at_ack);
    exp_t e;
    int   cyc   = 0;
    int   n_ce  = 0;
    int   n_oe  = 0;
    int   n_we  = 0;
    logic multi = 1'b0;
    sb.push_back(model(we, a));
    bus.req    = 1'b1;
    bus.req_we = we;
    bus.req_a  = a;
    bus.req_wd = wd;
    tick();
    if (!hold) bus.req = 1'b0;
    cyc = 1;
    while (!bus.ack && cyc < 40) begin
      if (dev_ce_n != 5'h1F) n_ce++;
      if ($countones(~dev_ce_n) > 1) multi = 1'b1;
      if (!dev_oe_n) n_oe++;
      if (!dev_we_n) n_we++;
      tick();
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_ack_seen"}, bus.ack, 1'b1);
    chk({tag, "_latency"}, cyc, e.lat);
    chk({tag, "_ce_cycles"}, n_ce, e.ce);
    chk({tag, "_oe_cycles"}, n_oe, e.oe);
    chk({tag, "_we_cycles"}, n_we, e.we);
    chk({tag, "_one_hot_ce"}, multi, 1'b0);
    chk({tag, "_wr_fault"}, bus.wr_fault, e.wf);
    chk({tag, "_done_strobes"}, {dev_ce_n, dev_oe_n, dev_we_n}, 7'h7F);
    chk({tag, "_dev_a"}, dev_a, a[18:0]);
    if (we) chk({tag, "_dev_wd"}, dev_wd, wd);
    if (e.chk_rd) chk({tag, "_rd_data"}, bus.rd_data, e.rd);
    if (clr_at_ack) fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk({tag, "_ack_drop"}, {bus.ack, bus.wr_fault, bus.busy}, 3'b000);
  endtask

  initial begin
    rin_n      = 1'b0;
    bus.req    = 1'b0;
    bus.req_we = 1'b0;
    bus.req_a  = '0;
    bus.req_wd = '0;
    fault_clr  = 1'b0;
    ws_cfg     = {3'd0, 3'd1, 3'd7, 3'd3, 3'd0};
    wp_mask    = 5'b01000;
    present    = 5'b01100;
    dev_rd     = {8'h66, 8'h99, 8'hC7, 8'h5A, 8'h3E};
    repeat (3) tick();

    chk("rst_ctrl", {bus.ack, bus.busy, bus.wr_fault}, 3'b000);
    chk("rst_strobes", {dev_ce_n, dev_oe_n, dev_we_n}, 7'h7F);
    chk("rst_rd_data", bus.rd_data, 8'hFF);
    chk("rst_dev_a_wd", {dev_a, dev_wd}, 27'h0);
    chk("rst_fault", {fault_valid, fault_a}, 23'h0);
    rin_n = 1'b1;
    tick();

    access("t1_rom_rd", 1'b0, 22'h000123, 8'h00, 1'b0, 1'b0);
    chk("t1_rd_3e", bus.rd_data, 8'h3E);

    access("t2_ram_wr", 1'b1, 22'h080010, 8'hA5, 1'b0, 1'b0);
    chk("t2_dev_a", dev_a, 19'h00010);

    access("t3_rom_wr", 1'b1, 22'h000000, 8'h77, 1'b0, 1'b0);
`ifdef Z88_MEM_FAULT_LATCH_EN
    chk("t3_fault_set", {fault_valid, fault_a}, {1'b1, 22'h000000});
`else
    chk("t3_fault_off", {fault_valid, fault_a}, 23'h0);
`endif
    access("t3_card2_wr", 1'b1, 22'h200000, 8'h55, 1'b0, 1'b0);
`ifdef Z88_MEM_FAULT_LATCH_EN
    chk("t3_fault_held", {fault_valid, fault_a}, {1'b1, 22'h000000});
`else
    chk("t3_fault_off2", {fault_valid, fault_a}, 23'h0);
`endif
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("t3_fault_clr", fault_valid, 1'b0);

    access("t4_absent_rd", 1'b0, 22'h3FFFFF, 8'h00, 1'b0, 1'b0);
    access("t4_card2_rd", 1'b0, 22'h200004, 8'h00, 1'b0, 1'b0);
    access("t4_ram_rd", 1'b0, 22'h0FFFFF, 8'h00, 1'b0, 1'b0);

    access("t5_card1_hold", 1'b0, 22'h100005, 8'h00, 1'b1, 1'b0);
    tick();
    chk("t5_reaccess", bus.busy, 1'b1);
    bus.req = 1'b0;
    tick();
    chk("t5_strobe_live", {dev_oe_n, dev_ce_n}, {1'b0, 5'b11011});
    rin_n = 1'b0;
    #1;
    chk("t5_rst_strobes", {dev_ce_n, dev_oe_n, dev_we_n}, 7'h7F);
    chk("t5_rst_ctrl", {bus.ack, bus.busy}, 2'b00);
    tick();
    tick();
    chk("t5_rst_no_ack", {bus.ack, bus.busy}, 2'b00);
    rin_n = 1'b1;
    tick();
    chk("t5_post_rst", {bus.busy, bus.rd_data}, {1'b0, 8'hFF});

    access("t6_rom_wr", 1'b1, 22'h000040, 8'h12, 1'b0, 1'b0);
`ifdef Z88_MEM_FAULT_LATCH_EN
    chk("t6_first_fault", {fault_valid, fault_a}, {1'b1, 22'h000040});
`else
    chk("t6_fault_off", {fault_valid, fault_a}, 23'h0);
`endif
    access("t6_race_wr", 1'b1, 22'h200100, 8'h34, 1'b0, 1'b1);
`ifdef Z88_MEM_FAULT_LATCH_EN
    chk("t6_race_wins", {fault_valid, fault_a}, {1'b1, 22'h200100});
`else
    chk("t6_race_off", {fault_valid, fault_a}, 23'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/z88_mem_bus.md
Name: z88_mem_bus

Overview:
Parametrised memory bus controller between the CPU/Blink address path and the physical memory devices. It decodes the 22-bit banked address into internal ROM, internal RAM and NSLOT-1 card slots, and drives per-device chip-select, output-enable and write-enable strobes. Each device has its own programmable wait-state count, and write-protect and slot-present masks gate every access. Read data is registered and returned to the requester, and each access completes with a one-cycle ack.

Parameters:
NSLOT, 4, number of 1 MB slots; slot 0 is internal and holds ROM in the lower half and RAM in the upper half.
AW, 22, width of the banked address req_a.
DAW, 19, device address width driven on dev_a (512 KB per device).
WS_W, 3, width of the per-device wait-state count.
NDEV is derived, not set: NDEV = NSLOT+1. Device 0 is internal ROM, device 1 is internal RAM, devices 2..NSLOT are cards 1..NSLOT-1.

Ports:
mck  in  1  master clock
rin_n  in  1  asynchronous active-low reset
req  in  1  access request; sampled only in IDLE
req_we  in  1  1 = write, 0 = read
req_a  in  AW  banked address
req_wd  in  8  write data
busy  out  1  high in every state except IDLE
ack  out  1  one-cycle completion pulse
rd_data  out  8  registered read data; valid from the ack cycle until the next ack
wr_fault  out  1  one-cycle pulse, coincident with ack, on a write to a protected device
ws_cfg  in  NDEV*WS_W  wait states per device; field i is bits [i*WS_W +: WS_W]
wp_mask  in  NDEV  write-protect per device; device 0 is always protected regardless of this mask
present  in  NDEV  device populated; devices 0 and 1 are treated as always present
dev_a  out  DAW  device address
dev_wd  out  8  device write data
dev_ce_n  out  NDEV  per-device chip select, active low
dev_oe_n  out  1  shared output enable, active low
dev_we_n  out  1  shared write enable, active low
dev_rd  in  NDEV*8  per-device read data
fault_valid  out  1  sticky fault flag (optional feature)
fault_a  out  AW  address of the first fault (optional feature)
fault_clr  in  1  clears the sticky fault (optional feature)

Behaviour:
- Decode:
  - slot = req_a[AW-1:AW-2]; the slot index must be less than NSLOT.
  - Slot 0 maps to device req_a[AW-3] (0 = ROM, 1 = RAM).
  - Slot k>0 maps to device k+1.
  - dev_a = req_a[DAW-1:0].
- Reset (asynchronous, rin_n=0):
  - state=IDLE.
  - dev_ce_n all 1; dev_oe_n=1; dev_we_n=1.
  - ack=0, busy=0, wr_fault=0.
  - rd_data=8'hFF, dev_a=0, dev_wd=0.
  - fault_valid=0, fault_a=0.
  - Reset mid-access drops all strobes immediately; no ack is issued.
- FSM states: IDLE -> SETUP -> STROBE -> DONE -> IDLE.
- IDLE:
  - On req=1, latch the address, write data, device index, req_we and ws=ws_cfg[dev], then go to SETUP.
  - On req=0, stay in IDLE.
- SETUP (1 cycle):
  - dev_a and dev_wd are driven; dev_ce_n[dev]=0 if the access is allowed.
  - oe_n and we_n stay high.
- STROBE (ws+1 cycles):
  - Read allowed: dev_oe_n=0.
  - Write allowed: dev_we_n=0.
  - A down-counter is loaded with ws. The last cycle is when the counter is 0; on that cycle, capture dev_rd[dev] into rd_data for a read.
- DONE (1 cycle):
  - All strobes high, ack=1.
  - Next state is IDLE, so back-to-back requests are separated by at least one IDLE cycle.
- Latency: ack asserts ws+3 cycles after the cycle in which req is sampled.
- Blocked access: present[dev]=0, or a write with the device protected.
  - The FSM still runs the full sequence and the latency is unchanged.
  - No dev_ce_n, dev_oe_n or dev_we_n assertion is made.
  - A blocked read returns rd_data=8'hFF.
  - A blocked write pulses wr_fault together with ack.
- A read from an absent slot is not a fault.
- ws=0 gives a single-cycle strobe. ws = 2^WS_W - 1 gives 2^WS_W strobe cycles; the counter must not wrap.
- req asserted while busy=1 is ignored and not queued.
- Exactly one dev_ce_n bit is low at any time, or none.

Optional Feature:
Macro Z88_MEM_FAULT_LATCH_EN.
- Defined:
  - On the first wr_fault while fault_valid=0, latch the latched req_a into fault_a and set fault_valid.
  - Later faults do not overwrite fault_a.
  - fault_clr=1 clears fault_valid.
  - If fault_clr and a new fault occur in the same cycle, the new fault wins: it is latched and fault_valid stays 1.
- Undefined: fault_valid and fault_a are tied to 0, fault_clr is ignored, and no registers are inferred.

Decomposition:
- Package z88_mem_pkg holds:
  - the DEV_ROM=0 and DEV_RAM=1 constants;
  - the card device offset constant (1);
  - the FSM state enum (IDLE, SETUP, STROBE, DONE);
  - a function computing device width as clog2(NDEV).
- Sub-module z88_mem_decode: purely combinational req_a -> device index and dev_a, parametrised by NSLOT, AW and DAW.

Test Plan:
1. ROM read: req_a=22'h000123, ws_cfg[0]=0, dev_rd[0]=8'h3E. Expect dev_ce_n[0]=0 for 2 cycles, dev_oe_n=0 for 1 cycle, ack 3 cycles after req, rd_data=8'h3E.
2. RAM write with waits: req_a=22'h080010, req_we=1, req_wd=8'hA5, ws_cfg[1]=3. Expect dev_we_n=0 for exactly 4 cycles with dev_wd=8'hA5, dev_a=19'h00010, ack at cycle 6, wr_fault=0.
3. Protected write: write to ROM (22'h000000), and to card 2 (22'h200000) with wp_mask[3]=1. Expect no strobe assertion, ack plus wr_fault on the same cycle, and fault_a=22'h000000 held with the macro defined.
4. Absent slot read: req_a=22'h3FFFFF with present[4]=0. Expect rd_data=8'hFF, no dev_ce_n low, ack at cycle 3.
5. Busy ignore and reset: req held high across a ws=7 access to card 1. Expect exactly one ack, then a new access after one IDLE cycle. rin_n pulsed low mid-STROBE: all strobes high immediately, no ack, busy=0.
6. Fault clear race (macro defined): fault_clr and a second protected write land on the same cycle. Expect fault_valid stays 1 and fault_a is updated to the new address.
